mac_simd_ctrl: RTL and testbench

MAC_SIMD_CTRL -- requirements
Module: mac_simd_ctrl

---
 rtl/mac_simd_ctrl_pkg.sv | 24 ++
 rtl/mac_simd_unpack.sv | 18 +
 rtl/mac_simd_ctrl.sv | 120 ++++++++++++
 tb/tb_mac_simd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_simd_ctrl_pkg.sv
// Shared widths, bounds and state type for the packed two-lane MAC controller.
package mac_simd_ctrl_pkg;

  localparam int OPND_W     = 8;
  localparam int LANE_W     = 18;
  localparam int LANE_SHIFT = 18;
  localparam int ACC_W      = 24;
  localparam int MAC_AD_W   = 27;
  localparam int MAC_B_W    = 18;
  localparam int MAC_P_W    = 48;

  localparam int K_LEN_MIN   = 1;
  localparam int K_LEN_MAX   = 256;
  localparam int MAC_LAT_MIN = 1;
  localparam int MAC_LAT_MAX = 8;

  localparam int CNT_W = $clog2(K_LEN_MAX);

  typedef enum logic {
    IDLE,
    ISSUE
  } issue_state_e;

endpackage

// File: rtl/mac_simd_unpack.sv
// Splits the packed DSP product into its two signed lanes; the low lane's sign
// borrows one from the high lane, so it is added back here.
module mac_simd_unpack
  import mac_simd_ctrl_pkg::*;
(
  input  logic        [MAC_P_W-1:0] p,
  output logic signed [LANE_W-1:0]  hi,
  output logic signed [LANE_W-1:0]  lo
);

  logic unused_p_top;

  assign lo = p[LANE_W-1:0];
  assign hi = p[LANE_SHIFT+LANE_W-1:LANE_SHIFT] + {{(LANE_W-1){1'b0}}, p[LANE_W-1]};

  assign unused_p_top = ^p[MAC_P_W-1:LANE_SHIFT+LANE_W];

endmodule

// File: rtl/mac_simd_ctrl.sv
// Drives one DSP as two 8x8 MAC lanes: packs weights into A/D, tracks beats
// through the DSP pipeline with tags and accumulates K_LEN-beat dot products.
module mac_simd_ctrl
  import mac_simd_ctrl_pkg::*;
#(
  parameter int K_LEN   = 9,
  parameter int MAC_LAT = 3
) (
  input  logic                 apClk,
  input  logic                 apRst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPND_W-1:0]    in_act,
  input  logic [OPND_W-1:0]    in_w0,
  input  logic [OPND_W-1:0]    in_w1,
  output logic [MAC_AD_W-1:0]  mac_a,
  output logic [MAC_AD_W-1:0]  mac_d,
  output logic [MAC_B_W-1:0]   mac_b,
  output logic                 mac_ce,
  output logic                 mac_start,
  input  logic [MAC_P_W-1:0]   mac_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_r0,
  output logic [ACC_W-1:0]     out_r1
);

  logic                     stall;
  logic                     accept;
  logic                     last_beat;
  logic                     exit_valid;
  logic                     exit_last;
  issue_state_e             state;
  logic [CNT_W-1:0]         beat_cnt;
  logic [MAC_LAT-1:0]       tag_valid;
  logic [MAC_LAT-1:0]       tag_last;
  logic signed [LANE_W-1:0] lane_hi;
  logic signed [LANE_W-1:0] lane_lo;
  logic signed [ACC_W-1:0]  hi_ext;
  logic signed [ACC_W-1:0]  lo_ext;
  logic signed [ACC_W-1:0]  acc0;
  logic signed [ACC_W-1:0]  acc1;

  assign stall     = out_valid & ~out_ready;
  assign mac_ce    = ~stall;
  assign in_ready  = ~stall & ~apRst;
  assign accept    = in_valid & in_ready;
  assign last_beat = accept & (beat_cnt == CNT_W'(K_LEN - 1));
  assign mac_start = (state == ISSUE) | accept | (|tag_valid);

  // Operands are zeroed when idle so the DSP never sees stale data.
  assign mac_a = accept ? {{(MAC_AD_W-OPND_W-LANE_SHIFT){in_w0[OPND_W-1]}}, in_w0, {LANE_SHIFT{1'b0}}} : '0;
  assign mac_d = accept ? {{(MAC_AD_W-OPND_W){in_w1[OPND_W-1]}}, in_w1} : '0;
  assign mac_b = accept ? {{(MAC_B_W-OPND_W){in_act[OPND_W-1]}}, in_act} : '0;

  always_ff @(posedge apClk or posedge apRst) begin
    if (apRst) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        state    <= IDLE;
        beat_cnt <= '0;
      end else begin
        state    <= ISSUE;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  mac_simd_unpack u_unpack (
    .p  (mac_p),
    .hi (lane_hi),
    .lo (lane_lo)
  );

  assign hi_ext     = {{(ACC_W-LANE_W){lane_hi[LANE_W-1]}}, lane_hi};
  assign lo_ext     = {{(ACC_W-LANE_W){lane_lo[LANE_W-1]}}, lane_lo};
  assign exit_valid = tag_valid[MAC_LAT-1];
  assign exit_last  = tag_last[MAC_LAT-1];

  // Tags mirror the DSP pipeline, so everything here freezes with mac_ce.
  always_ff @(posedge apClk or posedge apRst) begin
    if (apRst) begin
      tag_valid <= '0;
      tag_last  <= '0;
      acc0      <= '0;
      acc1      <= '0;
      out_valid <= 1'b0;
      out_r0    <= '0;
      out_r1    <= '0;
    end else begin
      if (mac_ce) begin
        tag_valid[0] <= accept;
        tag_last[0]  <= last_beat;
        for (int i = 1; i < MAC_LAT; i++) begin
          tag_valid[i] <= tag_valid[i-1];
          tag_last[i]  <= tag_last[i-1];
        end
        if (exit_valid) begin
          if (exit_last) begin
            out_r0 <= acc0 + hi_ext;
            out_r1 <= acc1 + lo_ext;
            acc0   <= '0;
            acc1   <= '0;
          end else begin
            acc0 <= acc0 + hi_ext;
            acc1 <= acc1 + lo_ext;
          end
        end
      end
      if (mac_ce && exit_valid && exit_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_simd_ctrl.sv
// Scoreboard bench: three controllers (K_LEN 4, 1, 256) each feeding a
// behavioural DSP; expected dot products come from plain integer sums.
module tb_mac_simd_ctrl;

  localparam int NDUT    = 3;
  localparam int MAC_LAT = 3;

  typedef struct {
    int     dut;
    longint r0;
    longint r1;
  } exp_t;

  logic        apClk;
  logic        apRst;
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [7:0]  in_act    [NDUT];
  logic [7:0]  in_w0     [NDUT];
  logic [7:0]  in_w1     [NDUT];
  logic [26:0] mac_a     [NDUT];
  logic [26:0] mac_d     [NDUT];
  logic [17:0] mac_b     [NDUT];
  logic        mac_ce    [NDUT];
  logic        mac_start [NDUT];
  logic [47:0] mac_p     [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [23:0] out_r0    [NDUT];
  logic [23:0] out_r1    [NDUT];

  exp_t   expq[$];
  exp_t   mon_e;
  int     nVec = 0;
  int     nErr = 0;
  int     beatCnt [NDUT];
  longint sum0    [NDUT];
  longint sum1    [NDUT];
  bit     drvDone;

  initial apClk = 1'b0;
  always #5 apClk = ~apClk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int KL = (g == 0) ? 4 : (g == 1) ? 1 : 256;
    logic signed [47:0] pipe [MAC_LAT];

    mac_simd_ctrl #(.K_LEN(KL), .MAC_LAT(MAC_LAT)) dut (
      .apClk     (apClk),
      .apRst     (apRst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_act    (in_act[g]),
      .in_w0     (in_w0[g]),
      .in_w1     (in_w1[g]),
      .mac_a     (mac_a[g]),
      .mac_d     (mac_d[g]),
      .mac_b     (mac_b[g]),
      .mac_ce    (mac_ce[g]),
      .mac_start (mac_start[g]),
      .mac_p     (mac_p[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_r0    (out_r0[g]),
      .out_r1    (out_r1[g])
    );

    // Behavioural DSP: P = (A+D)*B, MAC_LAT clock-enabled stages.
    always @(posedge apClk) begin
      if (mac_ce[g]) begin
        pipe[0] <= ($signed({{21{mac_a[g][26]}}, mac_a[g]}) + $signed({{21{mac_d[g][26]}}, mac_d[g]}))
                   * $signed({{30{mac_b[g][17]}}, mac_b[g]});
        for (int k = 1; k < MAC_LAT; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mac_p[g] = pipe[MAC_LAT-1];
  end

  function automatic int kLen(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 256;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nVec++;
    if (act != exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelBeat(input int d, input int act, input int w0, input int w1);
    exp_t e;
    sum0[d] += longint'(w0 * act);
    sum1[d] += longint'(w1 * act);
    beatCnt[d]++;
    if (beatCnt[d] == kLen(d)) begin
      e.dut = d;
      e.r0  = sum0[d];
      e.r1  = sum1[d];
      expq.push_back(e);
      beatCnt[d] = 0;
      sum0[d]    = 0;
      sum1[d]    = 0;
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < NDUT; d++) begin
      beatCnt[d] = 0;
      sum0[d]    = 0;
      sum1[d]    = 0;
    end
  endtask

  task automatic applyStimulus(input int d, input int act, input int w0, input int w1);
    bit done = 1'b0;
    int n = 0;
    @(negedge apClk);
    in_act[d]   = 8'(act);
    in_w0[d]    = 8'(w0);
    in_w1[d]    = 8'(w1);
    in_valid[d] = 1'b1;
    while (!done && n < 200) begin
      #1;
      done = in_ready[d];
      @(posedge apClk);
      n++;
      if (!done) @(negedge apClk);
    end
    #1;
    in_valid[d] = 1'b0;
    if (done) modelBeat(d, act, w0, w1);
    else checkOutput("beat_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 600) begin
      @(negedge apClk);
      n++;
    end
    checkOutput("queue_drained", expq.size(), 0);
    repeat (MAC_LAT + 3) @(negedge apClk);
  endtask

  // Monitor: every handshake pops the oldest expected result.
  always @(negedge apClk) begin
    #2;
    for (int g = 0; g < NDUT; g++) begin
      if (!apRst && out_valid[g] && out_ready[g]) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_output", g, -1);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("dut_id", g, mon_e.dut);
          checkOutput("r0", longint'($signed(out_r0[g])), mon_e.r0);
          checkOutput("r1", longint'($signed(out_r1[g])), mon_e.r1);
        end
      end
    end
  end

  initial begin
    int lat;
    apRst = 1'b1;
    clearModel();
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      in_act[d]    = '0;
      in_w0[d]     = '0;
      in_w1[d]     = '0;
      out_ready[d] = 1'b1;
    end
    repeat (2) @(negedge apClk);
    #1;
    checkOutput("rst_out_valid", out_valid[0], 0);
    checkOutput("rst_out_r0", out_r0[0], 0);
    checkOutput("rst_out_r1", out_r1[0], 0);
    checkOutput("rst_mac_ce", mac_ce[0], 1);
    checkOutput("rst_mac_start", mac_start[0], 0);
    checkOutput("rst_in_ready", in_ready[0], 0);
    @(negedge apClk);
    apRst = 1'b0;

    // Constant group, plus last-beat-to-output latency.
    for (int b = 0; b < 4; b++) applyStimulus(0, 3, 2, -5);
    lat = 1;
    while (!out_valid[0] && lat < 20) begin
      @(posedge apClk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, MAC_LAT + 1);
    drain();

    // Single-beat groups, extremes exercise the lane borrow.
    applyStimulus(1, -128, -128, 127);
    drain();

    // Longest group at full negative magnitude.
    for (int b = 0; b < 256; b++) applyStimulus(2, -128, -128, -128);
    drain();

    // Backpressure: hold out_ready low while two groups are offered.
    out_ready[0] = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++)
          applyStimulus(0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                        $urandom_range(0, 255) - 128);
      end
      begin
        logic [23:0] cap0, cap1;
        int n = 0;
        while (!out_valid[0] && n < 100) begin
          @(negedge apClk);
          #1;
          n++;
        end
        checkOutput("stall_result_seen", out_valid[0], 1);
        cap0 = out_r0[0];
        cap1 = out_r1[0];
        repeat (10) begin
          @(negedge apClk);
          #1;
          checkOutput("stall_in_ready", in_ready[0], 0);
          checkOutput("stall_mac_ce", mac_ce[0], 0);
          checkOutput("stall_r0_hold", out_r0[0], cap0);
          checkOutput("stall_r1_hold", out_r1[0], cap1);
        end
        @(negedge apClk);
        out_ready[0] = 1'b1;
      end
    join
    drain();

    // Random groups with bubbles and random backpressure.
    drvDone = 1'b0;
    fork
      begin
        for (int b = 0; b < 12; b++) begin
          repeat ($urandom_range(0, 2)) @(negedge apClk);
          applyStimulus(0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                        $urandom_range(0, 255) - 128);
        end
        for (int b = 0; b < 6; b++)
          applyStimulus(1, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                        $urandom_range(0, 255) - 128);
        drvDone = 1'b1;
      end
      begin
        while (!drvDone) begin
          @(negedge apClk);
          out_ready[0] = ($urandom_range(0, 3) != 0);
          out_ready[1] = ($urandom_range(0, 3) != 0);
        end
        @(negedge apClk);
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
      end
    join
    drain();

    // Reset mid-group discards the partial group.
    applyStimulus(0, 7, 9, -3);
    applyStimulus(0, -7, 5, 11);
    @(negedge apClk);
    apRst = 1'b1;
    clearModel();
    #1;
    checkOutput("midrst_in_ready", in_ready[0], 0);
    checkOutput("midrst_mac_start", mac_start[0], 0);
    repeat (2) @(negedge apClk);
    apRst = 1'b0;
    for (int b = 0; b < 4; b++) applyStimulus(0, 1, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
